// File: rtl/diff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : diff_pkg
//  Description : Shared definitions for the diff kernel: one-hot state
//                encodings, per-state cycle counts, CALC sub-step indices
//                and array geometry defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package diff_pkg;

    localparam int c_depth_default = 256;
    localparam int c_w_default     = 32;

    // One-hot state encodings
    localparam int         c_state_w   = 5;
    localparam logic [4:0] c_st_idle   = 5'b00001;
    localparam logic [4:0] c_st_init   = 5'b00010;
    localparam logic [4:0] c_st_check  = 5'b00100;
    localparam logic [4:0] c_st_calc   = 5'b01000;
    localparam logic [4:0] c_st_ret    = 5'b10000;

    // Per-state cycle counts
    localparam int         c_cnt_w     = 3;
    localparam logic [2:0] c_cyc_init  = 3'd2;
    localparam logic [2:0] c_cyc_check = 3'd3;
    localparam logic [2:0] c_cyc_calc  = 3'd5;
    localparam logic [2:0] c_cyc_ret   = 3'd4;

    // CALC sub-steps (the increment happens on the last CALC cycle)
    localparam logic [2:0] c_calc_rd   = 3'd0;
    localparam logic [2:0] c_calc_sub  = 3'd2;
    localparam logic [2:0] c_calc_wr   = 3'd3;

    // Counter value of the final cycle of a state lasting 'cyc' cycles
    function automatic logic [2:0] last_cycle(input logic [2:0] cyc);
        return cyc - 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/diff_kernel_ram.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_ram
//  Description : DEPTH x W storage array with one synchronous write port and
//                one combinational read port. Contents are never reset.
//  Ports       : i_clk            - write clock (rising edge)
//                i_we/i_waddr/i_wdata - write port
//                i_raddr/o_rdata  - zero-latency read port
//  Revision    : 1.0 - initial release
// ============================================================================
module kernel_ram
    import diff_pkg::*;
#(
    parameter int DEPTH = c_depth_default,
    parameter int W     = c_w_default
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/diff.sv
`default_nettype none
// ============================================================================
//  Module      : diff
//  Description : Inverse prefix-sum kernel. For i in [0, n_eff) computes
//                a[i] = b[i] - b[i-1] (b[-1] = 0, modulo 2^W) and returns
//                a[n_eff-1], or 0 when n_eff == 0. n_eff = min(n, DEPTH).
//                Multi-cycle one-hot FSM with a per-state cycle counter.
//  Ports       : sys_clk, sys_rst_n       - clock, async active-low reset
//                start, n                 - run request and element count
//                busy, done, return_val   - run status and result
//                wr_en, wr_addr, wr_data  - load port into b (idle only)
//                rd_addr, rd_data         - combinational readback of a
//  Revision    : 1.0 - initial release
// ============================================================================
module diff
    import diff_pkg::*;
#(
    parameter int DEPTH = c_depth_default,
    parameter int W     = c_w_default
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     start,
    input  logic [W-1:0]             n,
    output logic                     busy,
    output logic                     done,
    output logic [W-1:0]             return_val,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    localparam int              c_aw      = $clog2(DEPTH);
    // Index/count width must hold the value DEPTH itself
    localparam int              c_nw      = c_aw + 1;
    localparam logic [c_nw-1:0] c_depth_n = c_nw'(DEPTH);

    logic [c_state_w-1:0] r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_nw-1:0]      r_n_eff;
    logic [c_nw-1:0]      r_i;
    logic [W-1:0]         r_prev;
    logic [W-1:0]         r_b_val;
    logic [W-1:0]         r_diff;

    logic [c_nw-1:0]      w_n_clamped;
    logic [c_cnt_w-1:0]   w_cnt_last;
    logic                 w_last;
    logic                 w_i_done;
    logic                 w_b_we;
    logic                 w_a_we;
    logic [W-1:0]         w_b_rdata;

    assign w_n_clamped = (n > W'(DEPTH)) ? c_depth_n : n[c_nw-1:0];
    assign w_i_done    = (r_i >= r_n_eff);

    // Load port reaches b only while idle; the kernel never writes b
    assign w_b_we = wr_en && (r_state == c_st_idle);
    assign w_a_we = (r_state == c_st_calc) && (r_cnt == c_calc_wr);

    always_comb begin
        w_cnt_last = '0;
        case (r_state)
            c_st_init:  w_cnt_last = last_cycle(c_cyc_init);
            c_st_check: w_cnt_last = last_cycle(c_cyc_check);
            c_st_calc:  w_cnt_last = last_cycle(c_cyc_calc);
            c_st_ret:   w_cnt_last = last_cycle(c_cyc_ret);
            default:    w_cnt_last = '0;
        endcase
    end

    assign w_last = (r_cnt == w_cnt_last);

    kernel_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_b_ram (
        .i_clk   (sys_clk),
        .i_we    (w_b_we),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_i[c_aw-1:0]),
        .o_rdata (w_b_rdata)
    );

    kernel_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_a_ram (
        .i_clk   (sys_clk),
        .i_we    (w_a_we),
        .i_waddr (r_i[c_aw-1:0]),
        .i_wdata (r_diff),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_n_eff    <= '0;
            r_i        <= '0;
            r_prev     <= '0;
            r_b_val    <= '0;
            r_diff     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            return_val <= '0;
        end else begin
            done <= 1'b0;

            if (r_state != c_st_idle) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_n_eff <= w_n_clamped;
                        busy    <= 1'b1;
                        r_state <= c_st_init;
                    end
                end

                c_st_init: begin
                    // r_diff doubles as the last a[] value written; clearing it
                    // here makes an n == 0 run return 0 instead of a stale value
                    r_i    <= '0;
                    r_prev <= '0;
                    r_diff <= '0;
                    if (w_last) begin
                        r_state <= c_st_check;
                    end
                end

                c_st_check: begin
                    if (w_last) begin
                        r_state <= w_i_done ? c_st_ret : c_st_calc;
                    end
                end

                c_st_calc: begin
                    if (r_cnt == c_calc_rd) begin
                        r_b_val <= w_b_rdata;
                    end
                    if (r_cnt == c_calc_sub) begin
                        r_diff <= r_b_val - r_prev;
                    end
                    if (r_cnt == c_calc_wr) begin
                        r_prev <= r_b_val;
                    end
                    if (w_last) begin
                        r_i     <= r_i + 1'b1;
                        r_state <= c_st_check;
                    end
                end

                c_st_ret: begin
                    // r_diff equals a[n_eff-1]: it is the value written on the
                    // final CALC pass, leaving the a read port free for rd_addr
                    if (w_last) begin
                        return_val <= r_diff;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/diff.md
# diff

Inverse of the prefix-sum kernel: recovers a source sequence from its running sums. For each i in [0, n), it reads `b[i]` from an internal source array and writes `a[i] = b[i] - b[i-1]` to an internal result array, with `b[-1] = 0`. It then returns `a[n-1]`. Like the other generated kernels, it is built as a multi-cycle FSM with a per-state cycle counter. It adds a start/done handshake plus load and readback ports so the sequencer and bench can drive it directly.

## Interface
Parameters:
- DEPTH, 256: entries per array; index width is clog2(DEPTH).
- W, 32: data width.

Ports:
- sys_clk  in  1  sole clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- n  in  W  element count; sampled on the accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when return_val is valid.
- return_val  out  W  `a[n-1]`; holds until the next accepted start.
- wr_en, wr_addr, wr_data  in  1 / 8 / W  write port into the source array `b`; honoured only while not busy.
- rd_addr  in  8  read address into the result array `a`.
- rd_data  out  W  combinational `a[rd_addr]`.

## Operation
States are one-hot. Each state except IDLE runs a fixed number of counter cycles, then branches and clears the counter.
- IDLE: waits for start. On start, latches `n_eff = min(n, DEPTH)`, then goes to INIT.
- INIT (2 cycles): sets i=0 and prev=0. Then goes to CHECK.
- CHECK (3 cycles): computes `i >= n_eff`. True goes to RET; false goes to CALC.
- CALC (5 cycles):
  - cycle 0: reads `b[i]`.
  - cycle 2: computes `diff = b[i] - prev`, modulo 2^W (no saturation).
  - cycle 3: writes `a[i] = diff` and sets `prev = b[i]`.
  - cycle 4: increments i, then returns to CHECK.
- RET (4 cycles): `return_val = a[n_eff-1]`, or 0 when `n_eff == 0`. On the last cycle it pulses done and returns to IDLE.

Rules and boundary cases:
- The returned value is always `a[n-1]` from the current run, never a stale value.
- start while busy: ignored, no queuing.
- wr_en while busy: write dropped.
- n = 0: no writes to `a`; return_val = 0.
- n > DEPTH: clamped to DEPTH, so no out-of-range access.
- rd_addr reads during a run return partially updated contents; this is legal.

Reset behaviour (asynchronous, including mid-run):
- State goes to IDLE; counter, i and prev go to 0.
- busy, done and return_val go to 0.
- Array contents are not cleared.

## Timing
- Latency from the edge that samples start to the done pulse: 8·n_eff + 9 cycles.
  - Breakdown: INIT 2 + CHECK 3·(n_eff+1) + CALC 5·n_eff + RET 4.
- busy falls in the same cycle done pulses.
- A new start is accepted on the cycle after done.
- return_val is stable from the done cycle onward.
- A load write is visible to a CALC that starts on the next cycle.
- rd_data has zero latency; a CALC write is visible on the following cycle.

## Structure
- Shared kernel package holds:
  - one-hot state encodings (IDLE, INIT, CHECK, CALC, RET);
  - per-state cycle counts (2/3/5/4);
  - DEPTH and W defaults.
- One sub-module, `kernel_ram`: DEPTH×W array with one synchronous write port and one combinational read port. It is instantiated twice, for `b` and for `a`.
- The `b` instance uses a muxed write port: load port when idle, no CALC writes.

## Test plan
- Load `b = {1,3,6,10}`, start with n=4 → `a = {1,2,3,4}`, return_val = 4, done at cycle 41.
- Load `b = {5,2}`, n=2 → `a[1] = 0xFFFFFFFD` (wrap-around), return_val = 0xFFFFFFFD, done at cycle 25.
- n=0 → no `a` writes (pre-seeded `a` unchanged), return_val = 0, done at cycle 9.
- n=300 with `b[i] = i` → `a[0] = 0`, `a[1..255] = 1`, return_val = 1, done at cycle 2057.
- During a run, pulse start and wr_en to `b[0]` → no restart, `b` unchanged, result identical to an undisturbed run.
- Assert sys_rst_n low at CALC of i=2 (n=4) → busy/done/return_val = 0 immediately, then a fresh start completes correctly.
